// File: rtl/mem_loader_pkg.sv
// Shared definitions for the stream-driven cache loader: header layout,
// target codes and FSM state encoding.
package mem_loader_pkg;

  typedef enum logic [1:0] {
    TGT_ICACHE  = 2'b00,
    TGT_DCACHE  = 2'b01,
    TGT_START   = 2'b10,
    TGT_ILLEGAL = 2'b11
  } target_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam int HDR_TGT_MSB  = 31;
  localparam int HDR_TGT_LSB  = 30;
  localparam int HDR_CNT_MSB  = 29;
  localparam int HDR_CNT_LSB  = 16;
  localparam int HDR_BASE_MSB = 15;
  localparam int HDR_BASE_LSB = 0;

  localparam int CNT_W  = HDR_CNT_MSB - HDR_CNT_LSB + 1;
  localparam int BASE_W = HDR_BASE_MSB - HDR_BASE_LSB + 1;

  function automatic target_e hdr_target(input logic [31:0] w);
    return target_e'(w[HDR_TGT_MSB:HDR_TGT_LSB]);
  endfunction

  function automatic logic [CNT_W-1:0] hdr_count(input logic [31:0] w);
    return w[HDR_CNT_MSB:HDR_CNT_LSB];
  endfunction

  function automatic logic [BASE_W-1:0] hdr_base(input logic [31:0] w);
    return w[HDR_BASE_MSB:HDR_BASE_LSB];
  endfunction

endpackage

// File: rtl/mem_loader.sv
// Parses a header/data word stream and writes frames into the instruction or
// data cache, then releases the processor on a START frame.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int IMEM_WORDS = 1024,
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic [31:0] icache_data,
  output logic [31:0] icache_addr,
  output logic        icache_we,
  output logic [31:0] dcache_data,
  output logic [31:0] dcache_addr,
  output logic        dcache_we,
  output logic        start,
  output logic        err
);

  localparam logic [16:0] IMEM_LIM = 17'(IMEM_WORDS);
  localparam logic [16:0] DMEM_LIM = 17'(DMEM_WORDS);

  state_e             state_q, state_d;
  logic               dc_sel_q, dc_sel_d;
  logic [BASE_W-1:0]  base_q, base_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               icache_we_q, icache_we_d;
  logic               dcache_we_q, dcache_we_d;
  logic [31:0]        icache_addr_q, icache_addr_d;
  logic [31:0]        icache_data_q, icache_data_d;
  logic [31:0]        dcache_addr_q, dcache_addr_d;
  logic [31:0]        dcache_data_q, dcache_data_d;
  logic               start_q, start_d;
  logic               err_q, err_d;

  logic               xfer;
  target_e            h_tgt;
  logic [CNT_W-1:0]   h_cnt;
  logic [BASE_W-1:0]  h_base;
  logic [16:0]        h_end;
  logic               range_bad;
  logic [16:0]        wr_addr;
  logic               last_word;

  assign s_ready = ~rst & ((state_q == ST_IDLE) | (state_q == ST_LOAD));
  assign xfer    = s_valid & s_ready;

  // Header decode and 17-bit range check; the sum cannot wrap at this width.
  assign h_tgt     = hdr_target(s_data);
  assign h_cnt     = hdr_count(s_data);
  assign h_base    = hdr_base(s_data);
  assign h_end     = {1'b0, h_base} + {3'b000, h_cnt};
  assign range_bad = h_end > ((h_tgt == TGT_DCACHE) ? DMEM_LIM : IMEM_LIM);

  assign wr_addr   = {1'b0, base_q} + {3'b000, idx_q};
  assign last_word = (idx_q == cnt_q - 14'd1);

  always_comb begin
    state_d       = state_q;
    dc_sel_d      = dc_sel_q;
    base_d        = base_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    icache_we_d   = 1'b0;
    dcache_we_d   = 1'b0;
    icache_addr_d = icache_addr_q;
    icache_data_d = icache_data_q;
    dcache_addr_d = dcache_addr_q;
    dcache_data_d = dcache_data_q;
    start_d       = start_q;
    err_d         = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          unique case (h_tgt)
            TGT_ILLEGAL: begin
              state_d = ST_ERR;
              err_d   = 1'b1;
            end
            TGT_START: begin
              state_d = ST_RUN;
              start_d = 1'b1;
            end
            default: begin
              // An empty frame is consumed silently and the next word is a header.
              if (h_cnt != '0) begin
                if (range_bad) begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
                end else begin
                  state_d  = ST_LOAD;
                  dc_sel_d = (h_tgt == TGT_DCACHE);
                  base_d   = h_base;
                  cnt_d    = h_cnt;
                  idx_d    = '0;
                end
              end
            end
          endcase
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          if (dc_sel_q) begin
            dcache_we_d   = 1'b1;
            dcache_addr_d = {15'd0, wr_addr};
            dcache_data_d = s_data;
          end else begin
            icache_we_d   = 1'b1;
            icache_addr_d = {15'd0, wr_addr};
            icache_data_d = s_data;
          end
          if (last_word) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + 14'd1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      dc_sel_q      <= 1'b0;
      base_q        <= '0;
      cnt_q         <= '0;
      idx_q         <= '0;
      icache_we_q   <= 1'b0;
      dcache_we_q   <= 1'b0;
      icache_addr_q <= '0;
      icache_data_q <= '0;
      dcache_addr_q <= '0;
      dcache_data_q <= '0;
      start_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      dc_sel_q      <= dc_sel_d;
      base_q        <= base_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      icache_we_q   <= icache_we_d;
      dcache_we_q   <= dcache_we_d;
      icache_addr_q <= icache_addr_d;
      icache_data_q <= icache_data_d;
      dcache_addr_q <= dcache_addr_d;
      dcache_data_q <= dcache_data_d;
      start_q       <= start_d;
      err_q         <= err_d;
    end
  end

  assign icache_we   = icache_we_q;
  assign icache_addr = icache_addr_q;
  assign icache_data = icache_data_q;
  assign dcache_we   = dcache_we_q;
  assign dcache_addr = dcache_addr_q;
  assign dcache_data = dcache_data_q;
  assign start       = start_q;
  assign err         = err_q;

endmodule
